// File: rtl/misr_pkg.sv
// Shared types, default constants and the y-vector fold used by the response
// signature collector.
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  localparam int          DEF_DATA_W = 241;
  localparam int          DEF_SIG_W  = 32;
  localparam int          DEF_CNT_W  = 16;
  localparam logic [31:0] DEF_POLY   = 32'h04C1_1DB7;
  localparam logic [31:0] DEF_SEED   = 32'h0000_0000;
  localparam int          DEF_NCHUNK = (DEF_DATA_W + DEF_SIG_W - 1) / DEF_SIG_W;

  // Zero-pad y to a whole number of chunks, then XOR the chunks together.
  function automatic logic [DEF_SIG_W-1:0] misr_fold(input logic [DEF_DATA_W-1:0] y);
    logic [DEF_NCHUNK*DEF_SIG_W-1:0] pad;
    logic [DEF_SIG_W-1:0]            acc;
    pad                   = '0;
    pad[DEF_DATA_W-1:0]   = y;
    acc                   = '0;
    for (int k = 0; k < DEF_NCHUNK; k++) begin
      acc = acc ^ pad[k*DEF_SIG_W +: DEF_SIG_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: seed load, enable-gated shift with
// polynomial feedback, XOR-in of the folded sample.
module misr_core
  import misr_pkg::*;
#(
  parameter int             W    = DEF_SIG_W,
  parameter logic [W-1:0]   POLY = DEF_POLY,
  parameter logic [W-1:0]   SEED = DEF_SEED
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_seed,
  input  logic         en,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Next signature: seed load has priority over a compaction step.
  always_comb begin
    value_d = value_q;
    if (load_seed) begin
      value_d = SEED;
    end else if (en) begin
      value_d = {value_q[W-2:0], 1'b0} ^ (value_q[W-1] ? POLY : {W{1'b0}}) ^ data_in;
    end else begin
      value_d = value_q;
    end
  end

  // Signature register.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/resp_misr_drain.sv
// Compacts the DUT output vector into a MISR over a programmed number of valid
// samples, then drains the signature MS byte first over valid/ready.
module resp_misr_drain
  import misr_pkg::*;
#(
  parameter int                 DATA_W = DEF_DATA_W,
  parameter int                 SIG_W  = DEF_SIG_W,
  parameter logic [SIG_W-1:0]   POLY   = DEF_POLY,
  parameter logic [SIG_W-1:0]   SEED   = DEF_SEED,
  parameter int                 CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_cycles,
  input  logic [DATA_W-1:0] y_in,
  input  logic              y_valid,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [7:0]        sig_data,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  sig_value
);

  localparam int NBYTES = SIG_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int NCHUNK = (DATA_W + SIG_W - 1) / SIG_W;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;
  logic               load_seed;
  logic               misr_en;
  logic [SIG_W-1:0]   fold;
  logic [SIG_W-1:0]   misr;

  if (DATA_W == DEF_DATA_W && SIG_W == DEF_SIG_W) begin : g_fold_pkg
    assign fold = misr_fold(y_in);
  end else begin : g_fold_gen
    logic [NCHUNK*SIG_W-1:0] y_pad;
    // Same fold as the package helper, for non-default widths.
    always_comb begin
      y_pad             = '0;
      y_pad[DATA_W-1:0] = y_in;
      fold              = '0;
      for (int k = 0; k < NCHUNK; k++) begin
        fold = fold ^ y_pad[k*SIG_W +: SIG_W];
      end
    end
  end

  misr_core #(.W(SIG_W), .POLY(POLY), .SEED(SEED)) u_misr (
    .clk       (clk),
    .rst       (rst),
    .load_seed (load_seed),
    .en        (misr_en),
    .data_in   (fold),
    .value     (misr)
  );

  // State, sample counter, byte index and done pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. The done cycle is still the tail of a run, so a start
  // arriving with done is dropped.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    load_seed = 1'b0;
    misr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d   = COMPACT;
          rem_d     = (num_cycles == {CNT_W{1'b0}}) ? CNT_W'(1) : num_cycles;
          idx_d     = '0;
          load_seed = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      COMPACT: begin
        if (y_valid) begin
          misr_en = 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = DRAIN;
            idx_d   = '0;
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end else begin
          state_d = COMPACT;
        end
      end
      DRAIN: begin
        if (sig_ready) begin
          if (idx_q == IDX_W'(NBYTES - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state; byte 0 of the stream is the MS byte.
  always_comb begin
    sig_valid = (state_q == DRAIN);
    busy      = (state_q != IDLE);
    done      = done_q;
    sig_value = misr;
    sig_data  = 8'h00;
    if (state_q == DRAIN) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (b == NBYTES - 1 - int'(idx_q)) begin
          sig_data = misr[b*8 +: 8];
        end else begin
          sig_data = sig_data;
        end
      end
    end else begin
      sig_data = 8'h00;
    end
  end

endmodule
